crc8_frame_sequencer: RTL and testbench

- Byte-level front end for the bit-serial CRC-8 datapath. Accepts a framed byte stream over a valid/ready handshake and serializes each byte MSB-first into an internal bit-serial CRC-8 register, one bit per clock.
- Reports the final CRC with a one-cycle strobe at end of frame.
- Sits between a packet source (UART/SPI framer) and the consumer that appends or checks the CRC.

---
 rtl/crc8_frame_sequencer.sv | 108 ++++++++++
 tb/tb_crc8_frame_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_sequencer.sv
// crc8_frame_sequencer: byte-framed front end feeding a bit-serial CRC-8 register, MSB first.
// Define CRC_CHECK_EN to add exp_crc / crc_match comparison of the final CRC.
module crc8_frame_sequencer #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    input  logic       abort,
`ifdef CRC_CHECK_EN
    input  logic [7:0] exp_crc,
    output logic       crc_match,
`endif
    output logic       busy,
    output logic       crc_valid,
    output logic [7:0] crc_value
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_q;
    logic [7:0] crc_q, shreg_q;
    logic [2:0] bit_cnt_q;
    logic       last_q, first_q;
    logic       fb;
    logic [7:0] crc_d;
`ifdef CRC_CHECK_EN
    logic [7:0] exp_q;
`endif

    assign fb    = shreg_q[7] ^ crc_q[7];
    assign crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            shreg_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            crc_valid <= 1'b0;
            crc_value <= 8'h00;
`ifdef CRC_CHECK_EN
            exp_q     <= 8'h00;
            crc_match <= 1'b0;
`endif
        end else begin
            crc_valid <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                first_q   <= 1'b1;
                bit_cnt_q <= 3'd0;
                s_ready   <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (s_valid) begin
                        shreg_q   <= s_data;
                        last_q    <= s_last;
                        bit_cnt_q <= 3'd0;
                        state_q   <= SHIFT;
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
`ifdef CRC_CHECK_EN
                        exp_q     <= exp_crc;
`endif
                        if (first_q) begin
                            crc_q   <= INIT;
                            first_q <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        crc_q     <= crc_d;
                        shreg_q   <= {shreg_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (last_q) begin
                                state_q   <= DONE;
                                crc_valid <= 1'b1;
                                crc_value <= crc_d;
`ifdef CRC_CHECK_EN
                                crc_match <= (crc_d == exp_q);
`endif
                            end else begin
                                state_q <= IDLE;
                                s_ready <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        first_q <= 1'b1;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_crc8_frame_sequencer.sv
// tb_crc8_frame_sequencer: random and directed frames checked against a frame-level CRC model.
module tb_crc8_frame_sequencer;
    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;

    logic       clk = 1'b0, reset_n = 1'b1;
    logic       s_valid = 1'b0, s_last = 1'b0, abort = 1'b0;
    logic [7:0] s_data = 8'h00, exp_crc = 8'h00;
    logic       s_ready, busy, crc_valid;
    logic [7:0] crc_value;
`ifdef CRC_CHECK_EN
    logic       crc_match;
`endif

    crc8_frame_sequencer #(.POLY(POLY), .INIT(INIT)) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .abort(abort),
`ifdef CRC_CHECK_EN
        .exp_crc(exp_crc), .crc_match(crc_match),
`endif
        .busy(busy), .crc_valid(crc_valid), .crc_value(crc_value)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0, hs_cyc = 0, v_cyc = 0;
    logic [7:0] seen[$];
    bit rnd_abort = 1'b0;

    // model: bytes of the open frame, and cycles left before the block is ready again
    logic [7:0] frame[$];
    int         rem = 0;
    bit         lastf = 1'b0, m_valid = 1'b0, m_match = 1'b0;
    logic [7:0] m_value = 8'h00, m_exp = 8'h00;

    function automatic logic [7:0] crc_of(input logic [7:0] q[$]);
        logic [7:0] c = INIT;
        foreach (q[i]) begin
            c ^= q[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %h expected %h", nm, act, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem = 0; frame.delete(); lastf = 0; m_valid = 0; m_value = 0; m_match = 0; m_exp = 0;
        end else begin
            m_valid = 0;
            if (abort) begin
                rem = 0;
                frame.delete();
            end else if (rem == 0) begin
                if (s_valid) begin
                    frame.push_back(s_data);
                    lastf = s_last;
                    m_exp = exp_crc;
                    rem = s_last ? 9 : 8;
                end
            end else begin
                rem--;
                if (lastf && rem == 1) begin
                    m_valid = 1;
                    m_value = crc_of(frame);
                    m_match = (m_value == m_exp);
                end
                if (lastf && rem == 0) frame.delete();
            end
        end
    end

    always @(negedge clk) begin
        check({s_ready, busy, crc_valid, crc_value} === {rem == 0, rem != 0, m_valid, m_value},
              "cycle_outputs", {21'd0, s_ready, busy, crc_valid, crc_value},
              {21'd0, rem == 0, rem != 0, m_valid, m_value});
`ifdef CRC_CHECK_EN
        check(crc_match === m_match, "cycle_match", {31'd0, crc_match}, {31'd0, m_match});
`endif
        if (crc_valid) begin
            seen.push_back(crc_value);
            v_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit l);
        int n = 0;
        while (!s_ready && n < 100) begin
            s_data = 8'($urandom); s_last = 1'($urandom); s_valid = 1'b1;
            abort = rnd_abort && ($urandom_range(0, 39) == 0);
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "ready_timeout", n, 100);
        s_data = b; s_last = l; s_valid = 1'b1;
        abort = rnd_abort && ($urandom_range(0, 29) == 0);
        @(negedge clk);
        abort = 1'b0;
        hs_cyc = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "idle_timeout", n, 100);
    endtask

    task automatic send_frame(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], i == q.size() - 1);
        s_valid = 1'b0;
        wait_idle();
    endtask

    logic [7:0] nine[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check({s_ready, busy, crc_valid, crc_value} === 11'b1_0_0_00000000, "reset_vals",
              {21'd0, s_ready, busy, crc_valid, crc_value}, 32'h400);
        reset_n = 1'b1;
        @(negedge clk);

        check(crc_of('{8'h01}) == 8'h07, "model_01", crc_of('{8'h01}), 8'h07);
        check(crc_of('{8'hFF}) == 8'hF3, "model_FF", crc_of('{8'hFF}), 8'hF3);
        check(crc_of('{8'h00}) == 8'h00, "model_00", crc_of('{8'h00}), 8'h00);
        check(crc_of(nine) == 8'hF4, "model_check", crc_of(nine), 8'hF4);

        seen.delete();
        send_frame('{8'h01});
        check(seen.size() == 1 && seen[0] == 8'h07, "single_01", seen[0], 8'h07);
        check(v_cyc == hs_cyc + 8, "latency", v_cyc - hs_cyc, 8);

        seen.delete();
        send_frame('{8'hFF});
        check(seen.size() == 1 && seen[0] == 8'hF3, "single_FF", seen[0], 8'hF3);
        seen.delete();
        send_frame('{8'h00});
        check(seen.size() == 1 && seen[0] == 8'h00, "single_00", seen[0], 8'h00);

        seen.delete();
        exp_crc = 8'hF4;
        send_frame(nine);
        check(seen.size() == 1 && seen[0] == 8'hF4, "nine_byte", seen[0], 8'hF4);
`ifdef CRC_CHECK_EN
        check(crc_match === 1'b1, "match_F4", {31'd0, crc_match}, 1);
        exp_crc = 8'hF5;
        send_frame(nine);
        check(crc_match === 1'b0, "match_F5", {31'd0, crc_match}, 0);
`endif

        seen.delete();
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check(seen.size() == 2 && seen[0] == 8'h07 && seen[1] == 8'hF3, "back_to_back",
              {seen[0], seen[1]}, 16'h07F3);

        seen.delete();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check(crc_value == 8'hF3, "abort_holds_value", crc_value, 8'hF3);
        send_frame(nine);
        check(seen.size() == 1 && seen[0] == 8'hF4, "abort_retry", seen[0], 8'hF4);

        send_byte(8'h31, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check({s_ready, busy, crc_valid, crc_value} === 11'b1_0_0_00000000, "async_reset",
                 {21'd0, s_ready, busy, crc_valid, crc_value}, 32'h400);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        rnd_abort = 1'b1;
        repeat (40) begin
            q.delete();
            repeat ($urandom_range(1, 5)) q.push_back(8'($urandom));
            exp_crc = $urandom_range(0, 1) ? crc_of(q) : 8'($urandom);
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(q);
        end
        rnd_abort = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
